// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: loader and receiver state
// encodings, the image size limit and the length-header size.
package prog_loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_LEN_LO,
    LD_DATA,
    LD_DONE,
    LD_ERR
  } loader_state_t;

  // UART byte receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Largest image, in 32-bit words, that fits the 14-bit word address space.
  localparam int unsigned MAX_WORDS = 16384;

  // The word count travels as a big-endian header of this many bytes.
  localparam int unsigned HDR_BYTES = 2;

  // A word count is usable when it is non-zero and fits instruction memory.
  function automatic logic len_ok(input logic [15:0] n);
    return (n != 16'd0) && (n <= 16'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART byte receiver. Works on an already synchronized serial line:
// detects a falling edge, confirms the start bit at half a bit, samples the
// eight data bits LSB first at their centres and checks the stop bit.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        r_state;
  rx_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_rx_prev;
  logic             r_byte_valid;
  logic             r_frame_err;

  logic w_fall;
  logic w_half;
  logic w_bit_end;

  assign w_fall    = r_rx_prev & ~rx;
  assign w_half    = (r_cnt == HALF_LAST);
  assign w_bit_end = (r_cnt == BIT_LAST);

  // Receiver state register.
  always_ff @(posedge clock) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // together from pre-edge values, independent of statement order.
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode for one frame.
  always_comb begin
    // NOTE: the default comes first so every path assigns w_next; a path
    // that left it unassigned would infer a latch.
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_half) w_next = rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_bit_end) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  // Bit timing, data shift register and one-cycle result strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_rx_prev    <= 1'b1;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_prev    <= rx;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
        end
        RX_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
        RX_DATA: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_shift   <= {rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_bit_end) begin
            r_cnt        <= '0;
            r_byte_valid <= rx;
            r_frame_err  <= ~rx;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_shift;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/prog_loader.sv
// UART program loader. Receives a big-endian word count followed by that
// many big-endian 32-bit words and writes them to instruction memory from
// word address 0, holding the CPU in reset until the image is complete.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 200,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic        load_start,
  output logic        imem_we,
  output logic [13:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [14:0] words_loaded
);

  localparam int HDR_BITS = HDR_BYTES * 8;
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic                r_rx_meta;
  logic                r_rx_sync;
  loader_state_t       r_state;
  loader_state_t       w_next;
  logic [HDR_BITS-1:0] r_len;
  logic [23:0]         r_word;
  logic [1:0]          r_byte_idx;
  logic [14:0]         r_words;
  logic                r_we;
  logic [31:0]         r_wdata;
  logic [TMO_W-1:0]    r_tmo_cnt;

  logic                w_byte_valid;
  logic [7:0]          w_byte;
  logic                w_frame_err;
  logic                w_loading;
  logic                w_timeout;
  logic                w_last_write;
  logic [HDR_BITS-1:0] w_len_n;

  // Two-flop synchronizer; idles high like the line itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (r_rx_sync),
    .byte_valid(w_byte_valid),
    .byte_data (w_byte),
    .frame_err (w_frame_err)
  );

  assign w_loading    = (r_state == LD_LEN_HI) || (r_state == LD_LEN_LO) ||
                        (r_state == LD_DATA);
  assign w_timeout    = w_loading && r_rx_sync && (r_tmo_cnt == TMO_LAST);
  assign w_len_n      = {r_len[HDR_BITS-1:8], w_byte};
  assign w_last_write = r_we && (({1'b0, r_words} + 16'd1) == r_len);

  // Idle-line timer: counts consecutive high cycles with no byte delivered.
  always_ff @(posedge clock) begin
    if (reset || load_start || !w_loading || !r_rx_sync || w_byte_valid)
      r_tmo_cnt <= '0;
    else
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Loader state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= LD_IDLE;
    else       r_state <= w_next;
  end

  // Loader next-state and status outputs; load_start overrides everything.
  always_comb begin
    w_next    = r_state;
    cpu_hold  = (r_state != LD_IDLE);
    load_done = (r_state == LD_DONE);
    load_err  = (r_state == LD_ERR);
    if (load_start) begin
      w_next = LD_LEN_HI;
    end else begin
      case (r_state)
        LD_IDLE: w_next = LD_IDLE;
        LD_LEN_HI: begin
          if (w_frame_err || w_timeout) w_next = LD_ERR;
          else if (w_byte_valid)        w_next = LD_LEN_LO;
        end
        LD_LEN_LO: begin
          if (w_frame_err || w_timeout) w_next = LD_ERR;
          else if (w_byte_valid)        w_next = len_ok(w_len_n) ? LD_DATA : LD_ERR;
        end
        LD_DATA: begin
          if (w_last_write)                  w_next = LD_DONE;
          else if (w_frame_err || w_timeout) w_next = LD_ERR;
        end
        LD_DONE: w_next = LD_IDLE;
        LD_ERR:  w_next = LD_ERR;
        default: w_next = LD_IDLE;
      endcase
    end
  end

  // Header capture, word assembly, write strobe and word counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_len      <= '0;
      r_word     <= '0;
      r_byte_idx <= '0;
      r_words    <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (load_start) begin
        r_word     <= '0;
        r_byte_idx <= '0;
        r_words    <= '0;
      end else begin
        if (r_we) r_words <= r_words + 15'd1;
        case (r_state)
          LD_LEN_HI: if (w_byte_valid) r_len[HDR_BITS-1:8] <= w_byte;
          LD_LEN_LO: if (w_byte_valid) r_len[7:0] <= w_byte;
          LD_DATA: begin
            if (w_frame_err) begin
              r_byte_idx <= '0;
            end else if (w_byte_valid) begin
              if (r_byte_idx == 2'd3) begin
                r_we       <= 1'b1;
                r_wdata    <= {r_word, w_byte};
                r_byte_idx <= '0;
              end else begin
                r_word     <= {r_word[15:0], w_byte};
                r_byte_idx <= r_byte_idx + 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_words[13:0];
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a transaction-level model turns each
// byte stream into the list of memory writes and the final outcome, and a
// monitor compares every write strobe against that list.
module tb_prog_loader;

  localparam int CPB = 8;
  localparam int TMO = 1000;

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic        load_start;
  logic        imem_we;
  logic [13:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [14:0] words_loaded;

  int   n_vec = 0;
  int   n_mis = 0;
  int   n_done = 0;
  int   n_rx_ev = 0;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;
  wr_t  mon_e;

  wr_t        exp_q[$];
  logic [7:0] stream[$];
  int         bad_idx;

  prog_loader #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .load_start  (load_start),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the expected list.
  always @(negedge clock) begin
    if (imem_we) begin
      check("we_single_cycle", prev_we, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", imem_we, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", imem_addr, mon_e.addr);
        check("wr_data", imem_wdata, mon_e.data);
      end
    end
    if (load_done) begin
      n_done++;
      check("done_single_cycle", prev_done, 1'b0);
      check("hold_in_done", cpu_hold, 1'b1);
    end
    if (load_err) check("hold_in_err", cpu_hold, 1'b1);
    if (dut.u_rx.byte_valid || dut.u_rx.frame_err) n_rx_ev++;
    prev_we   = imem_we;
    prev_done = load_done;
  end

  // Reference model: expected writes and outcome of the current stream.
  task automatic model_load(output bit ok, output int words);
    int n;
    int base;
    ok    = 1'b0;
    words = 0;
    if (stream.size() < 2) return;
    if (bad_idx == 0 || bad_idx == 1) return;
    n = {stream[0], stream[1]};
    if (n == 0 || n > 16384) return;
    for (int w = 0; w < n; w++) begin
      base = 2 + 4 * w;
      if (base + 3 >= stream.size()) return;
      if (bad_idx >= 0 && bad_idx <= base + 3) return;
      exp_q.push_back(wr_t'{addr: 14'(w),
                            data: {stream[base], stream[base+1], stream[base+2], stream[base+3]}});
      words = w + 1;
    end
    ok = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1;
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    @(posedge clock); #1;
    rx = 1'b0;
    repeat (CPB) @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
    rx = good_stop;
    repeat (CPB) @(posedge clock);
    #1;
    rx = 1'b1;
    if (!good_stop) begin
      repeat (2 * CPB) @(posedge clock);
      #1;
    end
  endtask

  task automatic send_stream(input int max_gap);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], bad_idx != i);
      if (bad_idx == i) break;
      repeat ($urandom_range(0, max_gap)) @(posedge clock);
    end
  endtask

  // Wait (bounded) for done or error, then compare the final status.
  task automatic finish_load(input bit exp_ok, input int exp_words, input int d0);
    int t;
    for (t = 0; t < 4000; t++) begin
      if (n_done != d0 || load_err) break;
      @(negedge clock);
    end
    check("outcome_in_time", t < 4000, 1'b1);
    repeat (2) @(negedge clock);
    check("done_seen", n_done != d0, exp_ok);
    check("load_err", load_err, !exp_ok);
    check("cpu_hold_after", cpu_hold, !exp_ok);
    check("words_loaded", words_loaded, exp_words);
    check("writes_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_load(input bit do_start, input int max_gap);
    bit ok;
    int words;
    int d0;
    model_load(ok, words);
    d0 = n_done;
    if (do_start) pulse_start();
    send_stream(max_gap);
    finish_load(ok, words, d0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit         ok;
    int         words;
    int         d0;
    int         ev0;
    bit         hit;
    logic [15:0] n;

    reset      = 1'b1;
    rx         = 1'b1;
    load_start = 1'b0;
    bad_idx    = -1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_we", imem_we, 1'b0);
    check("rst_addr", imem_addr, 14'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_hold", cpu_hold, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_err", load_err, 1'b0);
    check("rst_words", words_loaded, 15'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);

    // Normal two-word load, with the model pinned to hand-computed writes.
    stream = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bad_idx = -1;
    model_load(ok, words);
    check("model_w0", exp_q[0], {14'd0, 32'h12345678});
    check("model_w1", exp_q[1], {14'd1, 32'hAABBCCDD});
    d0 = n_done;
    pulse_start();
    check("hold_in_len_hi", cpu_hold, 1'b1);
    send_stream(0);
    finish_load(ok, words, d0);
    check("normal_words_literal", words_loaded, 15'd2);

    // Bad lengths, then recovery with a valid stream.
    stream = {8'h00, 8'h00};
    run_load(1'b1, 0);
    stream = {8'h40, 8'h01};
    run_load(1'b1, 0);
    stream = {8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    run_load(1'b1, 0);

    // Largest legal length is accepted (loader sits in DATA, no error).
    stream = {8'h40, 8'h00};
    pulse_start();
    send_stream(0);
    repeat (20) @(negedge clock);
    check("len_16384_no_err", load_err, 1'b0);
    check("len_16384_hold", cpu_hold, 1'b1);

    // Framing error on the third data byte.
    stream = {8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    bad_idx = 4;
    run_load(1'b1, 0);
    bad_idx = -1;

    // Timeout after two data bytes.
    stream = {8'h00, 8'h01, 8'h11, 8'h22};
    model_load(ok, words);
    d0 = n_done;
    pulse_start();
    send_stream(0);
    repeat (900) @(negedge clock);
    check("timeout_not_early", load_err, 1'b0);
    repeat (200) @(negedge clock);
    check("timeout_fired", load_err, 1'b1);
    finish_load(ok, words, d0);

    // Restart during DATA after one write: next write goes to address 0.
    stream = {8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    model_load(ok, words);
    pulse_start();
    send_stream(0);
    repeat (4) @(negedge clock);
    check("restart_first_write_done", exp_q.size(), 0);
    stream = {8'h00, 8'h01, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(1'b1, 3);

    // load_start coincident with byte_valid discards that byte.
    stream = {8'h00, 8'h01, 8'h5A};
    model_load(ok, words);
    pulse_start();
    send_stream(0);
    hit = 1'b0;
    fork
      send_byte(8'hC3, 1'b1);
      begin
        for (int t = 0; t < 12 * CPB && !hit; t++) begin
          @(negedge clock);
          if (dut.u_rx.byte_valid) begin
            load_start = 1'b1;
            hit = 1'b1;
            @(posedge clock); #1;
            load_start = 1'b0;
          end
        end
      end
    join
    check("coincident_found", hit, 1'b1);
    stream = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(1'b0, 0);

    // Short low glitch in LEN_HI: no byte, no state change, load still works.
    pulse_start();
    ev0 = n_rx_ev;
    @(posedge clock); #1;
    rx = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    check("glitch_no_byte", n_rx_ev - ev0, 0);
    check("glitch_hold", cpu_hold, 1'b1);
    check("glitch_no_err", load_err, 1'b0);
    stream = {8'h00, 8'h01, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    run_load(1'b0, 0);

    // Reset in the middle of DATA abandons the load.
    stream = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    model_load(ok, words);
    pulse_start();
    send_stream(0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_we", imem_we, 1'b0);
    check("mid_rst_addr", imem_addr, 14'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_hold", cpu_hold, 1'b0);
    check("mid_rst_done", load_done, 1'b0);
    check("mid_rst_err", load_err, 1'b0);
    check("mid_rst_words", words_loaded, 15'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    stream = {8'h77, 8'h88};
    send_stream(0);
    repeat (4) @(negedge clock);
    check("post_rst_idle_hold", cpu_hold, 1'b0);
    check("post_rst_no_writes", exp_q.size(), 0);
    exp_q.delete();

    // Randomized loads: good, bad length, or framing error.
    for (int k = 0; k < 8; k++) begin
      int kind;
      stream.delete();
      bad_idx = -1;
      kind = $urandom_range(0, 3);
      if (kind == 2) begin
        case ($urandom_range(0, 2))
          0:       n = 16'd0;
          1:       n = 16'(16385 + $urandom_range(0, 100));
          default: n = 16'hFFFF;
        endcase
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
      end else begin
        n = 16'($urandom_range(1, 4));
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
        for (int b = 0; b < 4 * int'(n); b++) stream.push_back(8'($urandom));
        if (kind == 3) bad_idx = $urandom_range(0, stream.size() - 1);
      end
      run_load(1'b1, 2 * CPB);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
